// File: rtl/pcm_frame_assembler.sv
// ---------------------------------------------------------------------------
// pcm_frame_assembler
//
// Sits between uart_rx and the sample FIFO on the DAC board. Serial bytes are
// collected into 32-bit stereo frames {left[15:0], right[15:0]} and written
// to the FIFO with a single-cycle strobe. Frames that arrive while the FIFO
// is full are dropped and counted. A partial frame is discarded if the line
// goes idle for TIMEOUT_BYTES byte times. Hysteretic flow control drives the
// host handshake line.
//
// Wire byte order is L_lo, L_hi, R_lo, R_hi, landing in fifo_wr_data bits
// [23:16], [31:24], [7:0] and [15:8] respectively.
//
// Optional feature macro: PCM_SYNC_HEADER_EN
//   When defined, each frame must be preceded by the header 0xA5, 0x5A.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx_data       byte from uart_rx, valid while received=1
//   received      single-cycle byte strobe
//   fifo_full     FIFO full flag
//   fifo_fill     current FIFO occupancy
//   fifo_wr_en    single-cycle FIFO write strobe
//   fifo_wr_data  last assembled frame {L, R}
//   send_ok       host may send (drives UART_DSR_o)
//   low_water     registered (fifo_fill <= LOW_MARK)
//   resync        single-cycle pulse when a partial frame is discarded
//   frame_count   frames written, wraps
//   drop_count    frames dropped on full, saturates at 255
// ---------------------------------------------------------------------------
module pcm_frame_assembler #(
   parameter int CLK_FREQ      = 12_000_000,
   parameter int BAUDRATE      = 3_000_000,
   parameter int TIMEOUT_BYTES = 4,
   parameter int FILL_BITS     = 12,
   parameter int LOW_MARK      = 1228,
   parameter int HIGH_MARK     = 2048
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 received,
   input  logic                 fifo_full,
   input  logic [FILL_BITS-1:0] fifo_fill,
   output logic                 fifo_wr_en,
   output logic [31:0]          fifo_wr_data,
   output logic                 send_ok,
   output logic                 low_water,
   output logic                 resync,
   output logic [15:0]          frame_count,
   output logic [7:0]           drop_count
);

   // Idle gap in clock cycles; 10 bit times per byte. Computed in 64 bits so
   // fast clocks do not overflow the intermediate product.
   localparam int TIMEOUT_CYCLES =
      int'((longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ)) / longint'(BAUDRATE));
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FILL_BITS-1:0] LOW_LVL      = FILL_BITS'(LOW_MARK);
   localparam logic [FILL_BITS-1:0] HIGH_LVL     = FILL_BITS'(HIGH_MARK);

`ifdef PCM_SYNC_HEADER_EN
   typedef enum logic [2:0] {S_SYNC0, S_SYNC1, S_B0, S_B1, S_B2, S_B3} state_t;
   localparam state_t S_IDLE = S_SYNC0;
`else
   typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;
   localparam state_t S_IDLE = S_B0;
`endif

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             resync_next;
   logic             frame_done;
   logic [7:0]       l_lo, l_hi, r_lo;

   // Framing state register, idle-gap counter and the resync pulse. All of
   // them return to the idle position immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         resync <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         resync <= resync_next;
      end
   end

   // Next-state logic. A received byte always takes priority over timeout
   // expiry, so a byte landing on the last idle cycle is kept. The gap
   // counter sits at zero whenever we are waiting for the start of a frame,
   // which is why no resync can ever fire while the line is idle.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      resync_next = 1'b0;
      frame_done  = 1'b0;
      if (received) begin
         cnt_next = '0;
         case (state)
`ifdef PCM_SYNC_HEADER_EN
            S_SYNC0: if (rx_data == 8'hA5) state_next = S_SYNC1;
            S_SYNC1: begin
               if (rx_data == 8'h5A) begin
                  state_next = S_B0;
               end else if (rx_data != 8'hA5) begin
                  state_next  = S_SYNC0;
                  resync_next = 1'b1;
               end
            end
`endif
            S_B0:    state_next = S_B1;
            S_B1:    state_next = S_B2;
            S_B2:    state_next = S_B3;
            S_B3: begin
               state_next = S_IDLE;
               frame_done = 1'b1;
            end
            default: state_next = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         if (cnt == TIMEOUT_LAST) begin
            state_next  = S_IDLE;
            cnt_next    = '0;
            resync_next = 1'b1;
         end else begin
            cnt_next = cnt + CNT_W'(1);
         end
      end else begin
         cnt_next = '0;
      end
   end

   // Byte staging and FIFO write path. The first three bytes of a frame are
   // held privately so that an aborted frame never disturbs fifo_wr_data;
   // the output word only changes when a completed frame is written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_lo         <= '0;
         l_hi         <= '0;
         r_lo         <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         frame_count  <= '0;
         drop_count   <= '0;
      end else begin
         fifo_wr_en <= 1'b0;
         if (received) begin
            case (state)
               S_B0:    l_lo <= rx_data;
               S_B1:    l_hi <= rx_data;
               S_B2:    r_lo <= rx_data;
               default: ;
            endcase
         end
         if (frame_done) begin
            if (!fifo_full) begin
               fifo_wr_en   <= 1'b1;
               fifo_wr_data <= {l_hi, l_lo, rx_data, r_lo};
               frame_count  <= frame_count + 16'd1;
            end else if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end
      end
   end

   // Flow control with hysteresis: stop the host at the high mark, let it
   // resume only once the FIFO has drained to the low mark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         send_ok   <= 1'b1;
         low_water <= 1'b1;
      end else begin
         low_water <= (fifo_fill <= LOW_LVL);
         if (fifo_fill >= HIGH_LVL) begin
            send_ok <= 1'b0;
         end else if (fifo_fill <= LOW_LVL) begin
            send_ok <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pcm_frame_assembler.md
Name: pcm_frame_assembler

Overview:
- Sits between uart_rx and the sample fifo on the DAC board.
- Assembles the serial byte stream into 32-bit stereo frames, {left[15:0], right[15:0]}, and issues single-cycle FIFO writes.
- Drops frames when the FIFO is full and counts the drops.
- Resynchronises after line idle gaps.
- Drives hysteretic flow-control outputs for the host UART handshake lines.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz.
- BAUDRATE, 3_000_000, UART bit rate; used only for the timeout computation.
- TIMEOUT_BYTES, 4, idle gap in byte times (10 bits each) that aborts a partial frame.
- FILL_BITS, 12, width of the FIFO fill input.
- LOW_MARK, 1228, fill level at or below which sending is re-enabled.
- HIGH_MARK, 2048, fill level at or above which sending is stopped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from uart_rx; valid when received=1.
- received  in  1  single-cycle byte strobe.
- fifo_full  in  1  FIFO full flag.
- fifo_fill  in  FILL_BITS  current FIFO occupancy.
- fifo_wr_en  out  1  single-cycle FIFO write strobe.
- fifo_wr_data  out  32  assembled frame, {L, R}.
- send_ok  out  1  host may send; drives UART_DSR_o.
- low_water  out  1  registered (fifo_fill <= LOW_MARK).
- resync  out  1  single-cycle pulse when a partial frame is discarded.
- frame_count  out  16  frames written; wraps.
- drop_count  out  8  frames dropped on full; saturates at 255.

Behaviour:
- Reset values: all outputs 0 except send_ok=1 and low_water=1. State=S_B0, timeout counter=0.
- Byte order on the wire is L_lo, L_hi, R_lo, R_hi. Bytes land in fifo_wr_data[23:16], [31:24], [7:0], [15:8] respectively.
- State machine S_B0→S_B1→S_B2→S_B3→S_B0. The state advances only on received=1.
- On a received byte in S_B3:
  - If fifo_full=0: fifo_wr_en=1 on the next cycle (1-cycle latency from the strobe), and frame_count increments.
  - If fifo_full=1: no write, drop_count increments and saturates at 255.
  - fifo_wr_data holds its value until the next frame completes.
- fifo_wr_en is never high on two consecutive cycles.
- Timeout:
  - TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLK_FREQ/BAUDRATE (160 at defaults).
  - The counter clears on every received strobe and counts only while state != S_B0.
  - When the counter reaches TIMEOUT_CYCLES-1: state→S_B0, resync=1 for one cycle, partial bytes discarded (fifo_wr_data not cleared), counter cleared.
- Simultaneous received and timeout expiry: the byte wins. It is processed normally and no resync occurs.
- In S_B0 the counter holds at 0, so no resync is ever raised while idle.
- Flow control, registered, updated every cycle:
  - send_ok→0 when fifo_fill >= HIGH_MARK.
  - send_ok→1 when fifo_fill <= LOW_MARK.
  - Otherwise send_ok holds.
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous). No write is issued for the aborted frame.

Optional Feature:
- Macro: PCM_SYNC_HEADER_EN.
- With the macro defined:
  - Each frame is preceded by the header 0xA5, 0x5A.
  - States S_SYNC0→S_SYNC1 precede S_B0; S_B3 returns to S_SYNC0.
  - In S_SYNC0, any byte other than 0xA5 keeps state. In S_SYNC1, 0x5A advances to S_B0, 0xA5 stays in S_SYNC1, and any other byte returns to S_SYNC0 with resync=1.
  - Timeout counts in every state except S_SYNC0; on expiry, return to S_SYNC0.
  - Reset state is S_SYNC0.
- Without the macro: no header states; behaviour exactly as above.

Test Plan:
- Reset, then bytes 0x34,0x12,0x78,0x56 spaced 40 cycles → fifo_wr_en pulse 1 cycle after the 4th strobe, fifo_wr_data=0x12345678, frame_count=1.
- fifo_full=1 during 3 complete frames → no fifo_wr_en, drop_count=3. Then 300 frames with fifo_full=1 → drop_count=255.
- Send 2 bytes, idle 200 cycles, then 4 bytes 0x01,0x02,0x03,0x04 → resync pulse at cycle 160 after the 2nd byte, then fifo_wr_data=0x02010403.
- Sweep fifo_fill 0→2048→1500→1228 → send_ok 1, goes 0 at 2048, stays 0 at 1500, returns to 1 at 1228. low_water=1 exactly when fill <= 1228.
- Assert reset after 3 bytes of a frame, release, send 4 bytes → single write carrying only the new frame, frame_count=1.
- PCM_SYNC_HEADER_EN: stream 0x00,0xA5,0xA5,0x5A + 4 data bytes → one write. Stream 0xA5,0x11 → resync pulse, no write.
